// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - three-channel debounce with rise/fall pulses and saturating rise counters
// Each channel qualifies a new input value for DEBOUNCE_CYCLES consecutive edges before adopting it.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_1,
  input  logic             in_2,
  input  logic             in_3,
  input  logic             clr_counts,
  output logic             level_1,
  output logic             level_2,
  output logic             level_3,
  output logic             rise_1,
  output logic             rise_2,
  output logic             rise_3,
  output logic             fall_1,
  output logic             fall_2,
  output logic             fall_3,
  output logic [EVT_W-1:0] count_1,
  output logic [EVT_W-1:0] count_2,
  output logic [EVT_W-1:0] count_3,
  output logic             any_event
);

  localparam int STAB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [EVT_W-1:0]  CNT_MAX  = '1;

  logic [2:0]        in_w;
  logic [2:0]        level_q, level_d;
  logic [2:0]        rise_q, rise_d;
  logic [2:0]        fall_q, fall_d;
  logic [STAB_W-1:0] stab_q  [3];
  logic [STAB_W-1:0] stab_d  [3];
  logic [EVT_W-1:0]  count_q [3];
  logic [EVT_W-1:0]  count_d [3];

  assign in_w = {in_3, in_2, in_1};

  // A sample equal to the current level restarts qualification, so stab_d defaults to zero.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      level_d[c] = level_q[c];
      stab_d[c]  = '0;
      rise_d[c]  = 1'b0;
      fall_d[c]  = 1'b0;
      count_d[c] = count_q[c];
      if (in_w[c] != level_q[c]) begin
        if (stab_q[c] == STAB_MAX) begin
          level_d[c] = in_w[c];
          rise_d[c]  = in_w[c];
          fall_d[c]  = ~in_w[c];
        end else begin
          stab_d[c] = stab_q[c] + 1'b1;
        end
      end
      // Clear wins over a coincident rise; that rise is not counted.
      if (clr_counts) begin
        count_d[c] = '0;
      end else if (rise_d[c] && (count_q[c] != CNT_MAX)) begin
        count_d[c] = count_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      stab_q  <= '{default: '0};
      count_q <= '{default: '0};
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      stab_q  <= stab_d;
      count_q <= count_d;
    end
  end

  assign level_1   = level_q[0];
  assign level_2   = level_q[1];
  assign level_3   = level_q[2];
  assign rise_1    = rise_q[0];
  assign rise_2    = rise_q[1];
  assign rise_3    = rise_q[2];
  assign fall_1    = fall_q[0];
  assign fall_2    = fall_q[1];
  assign fall_3    = fall_q[2];
  assign count_1   = count_q[0];
  assign count_2   = count_q[1];
  assign count_3   = count_q[2];
  assign any_event = |rise_q || |fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - self-checking bench for input_debouncer
// Table vectors, directed corner sequences and random stimulus against a sample-window model.
module tb_input_debouncer;

  localparam int D  = 4;
  localparam int EW = 4;
  localparam int CMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic in_1, in_2, in_3, clr_counts;
  logic level_1, level_2, level_3;
  logic rise_1, rise_2, rise_3;
  logic fall_1, fall_2, fall_3;
  logic [EW-1:0] count_1, count_2, count_3;
  logic any_event;

  always #5 clk = ~clk;

  input_debouncer #(.DEBOUNCE_CYCLES(D), .EVT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_1(in_1), .in_2(in_2), .in_3(in_3), .clr_counts(clr_counts),
    .level_1(level_1), .level_2(level_2), .level_3(level_3),
    .rise_1(rise_1), .rise_2(rise_2), .rise_3(rise_3),
    .fall_1(fall_1), .fall_2(fall_2), .fall_3(fall_3),
    .count_1(count_1), .count_2(count_2), .count_3(count_3),
    .any_event(any_event)
  );

  logic [2:0] lvl_v, rise_v, fall_v;
  logic [EW-1:0] cnt_v [3];
  assign lvl_v  = {level_3, level_2, level_1};
  assign rise_v = {rise_3, rise_2, rise_1};
  assign fall_v = {fall_3, fall_2, fall_1};
  assign cnt_v[0] = count_1;
  assign cnt_v[1] = count_2;
  assign cnt_v[2] = count_3;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the level adopts a value once the last D samples since the previous change all differ from it.
  int m_level [3];
  int m_rise  [3];
  int m_fall  [3];
  int m_cnt   [3];
  int win     [3][D];
  int n_win   [3];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_level[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_cnt[c] = 0; n_win[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [2:0] in, input logic clr);
    int smp;
    bit all_diff;
    for (int c = 0; c < 3; c++) begin
      smp = int'(in[c]);
      if (n_win[c] == D) begin
        for (int i = 0; i < D - 1; i++) win[c][i] = win[c][i+1];
        win[c][D-1] = smp;
      end else begin
        win[c][n_win[c]] = smp;
        n_win[c]++;
      end
      all_diff = (n_win[c] == D);
      for (int i = 0; i < n_win[c]; i++) if (win[c][i] == m_level[c]) all_diff = 1'b0;
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (all_diff) begin
        m_level[c] = smp;
        m_rise[c]  = smp;
        m_fall[c]  = 1 - smp;
        n_win[c]   = 0;
      end
      if (clr) m_cnt[c] = 0;
      else if (m_rise[c] == 1 && m_cnt[c] < CMAX) m_cnt[c]++;
    end
  endtask

  task automatic cmp_model();
    int any_exp;
    any_exp = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("level_%0d", c + 1), int'(lvl_v[c]), m_level[c]);
      chk($sformatf("rise_%0d", c + 1), int'(rise_v[c]), m_rise[c]);
      chk($sformatf("fall_%0d", c + 1), int'(fall_v[c]), m_fall[c]);
      chk($sformatf("count_%0d", c + 1), int'(cnt_v[c]), m_cnt[c]);
      if (m_rise[c] != 0 || m_fall[c] != 0) any_exp = 1;
    end
    chk("any_event", int'(any_event), any_exp);
  endtask

  task automatic cyc(input logic [2:0] in, input logic clr);
    {in_3, in_2, in_1} = in;
    clr_counts = clr;
    @(posedge clk);
    model_edge(in, clr);
    #1;
    cmp_model();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_lvl"}, int'(lvl_v), 0);
    chk({nm, "_rise"}, int'(rise_v), 0);
    chk({nm, "_fall"}, int'(fall_v), 0);
    chk({nm, "_cnt"}, int'(count_1) + int'(count_2) + int'(count_3), 0);
    chk({nm, "_any"}, int'(any_event), 0);
  endtask

  typedef struct {
    logic [2:0] in;
    logic       clr;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] in, input logic clr, input logic [2:0] lvl,
                              input logic [2:0] rise, input logic [2:0] fall);
    vec_t v;
    v.in = in; v.clr = clr; v.lvl = lvl; v.rise = rise; v.fall = fall;
    tbl.push_back(v);
  endfunction

  initial begin
    int rises, anys;
    logic [2:0] cur;

    // in_2 pattern 1,1,1,0,1,1,1,1,1,1 with channel 1 held high and channel 3 low
    add(3'b011, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b001, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b001, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b011, 3'b010, 3'b000);
    add(3'b011, 1'b0, 3'b011, 3'b000, 3'b000);
    add(3'b011, 1'b0, 3'b011, 3'b000, 3'b000);
    // in_3 held 0, then 1, then 0 for six cycles each
    for (int k = 1; k <= 6; k++) add(3'b011, 1'b0, 3'b011, 3'b000, 3'b000);
    for (int k = 1; k <= 6; k++)
      add(3'b111, 1'b0, (k >= 4) ? 3'b111 : 3'b011, (k == 4) ? 3'b100 : 3'b000, 3'b000);
    for (int k = 1; k <= 6; k++)
      add(3'b011, 1'b0, (k >= 4) ? 3'b011 : 3'b111, 3'b000, (k == 4) ? 3'b100 : 3'b000);

    // Reset with in_1 high, then release between edges
    rst_n = 1'b0; in_1 = 1'b1; in_2 = 1'b0; in_3 = 1'b0; clr_counts = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc(3'b001, 1'b0);
      chk("s1_level_1", int'(level_1), (k >= 4) ? 1 : 0);
      chk("s1_rise_1", int'(rise_1), (k == 4) ? 1 : 0);
      chk("s1_fall_1", int'(fall_1), 0);
    end
    chk("s1_count_1", int'(count_1), 1);

    anys = 0;
    foreach (tbl[i]) begin
      cyc(tbl[i].in, tbl[i].clr);
      chk("tbl_lvl", int'(lvl_v), int'(tbl[i].lvl));
      chk("tbl_rise", int'(rise_v), int'(tbl[i].rise));
      chk("tbl_fall", int'(fall_v), int'(tbl[i].fall));
      if (i >= 10 && any_event) anys++;
    end
    chk("s3_any_cycles", anys, 2);
    chk("s3_count_3", int'(count_3), 1);
    chk("s2_count_2", int'(count_2), 1);

    // 20 qualified presses from a cleared counter
    cyc(3'b011, 1'b1);
    rises = 0;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 5; k++) cyc(3'b010, 1'b0);
      for (int k = 0; k < 5; k++) begin
        cyc(3'b011, 1'b0);
        if (rise_1) rises++;
      end
    end
    chk("s4_rise_pulses", rises, 20);
    chk("s4_count_sat", int'(count_1), CMAX);

    // Clear coinciding with a rise at count 5
    cyc(3'b011, 1'b1);
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 5; k++) cyc(3'b010, 1'b0);
      for (int k = 0; k < 5; k++) cyc(3'b011, 1'b0);
    end
    chk("s5_count_before", int'(count_1), 5);
    for (int k = 0; k < 5; k++) cyc(3'b010, 1'b0);
    for (int k = 0; k < 3; k++) cyc(3'b011, 1'b0);
    cyc(3'b011, 1'b1);
    chk("s5_rise_1", int'(rise_1), 1);
    chk("s5_count_cleared", int'(count_1), 0);
    chk("s5_level_1", int'(level_1), 1);
    cyc(3'b011, 1'b0);
    chk("s5_count_hold", int'(count_1), 0);

    // Asynchronous reset mid-cycle while channel 2 is two samples into qualification
    for (int k = 0; k < 5; k++) cyc(3'b001, 1'b0);
    chk("s6_level_2_low", int'(level_2), 0);
    cyc(3'b011, 1'b0);
    cyc(3'b011, 1'b0);
    chk("s6_level_1_pre", int'(level_1), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("s6_async");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc(3'b011, 1'b0);
      chk("s6_level_2", int'(level_2), (k >= 4) ? 1 : 0);
    end

    // Random stimulus with occasional clears
    cur = 3'b011;
    for (int r = 0; r < 600; r++) begin
      for (int c = 0; c < 3; c++) if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      cyc(cur, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Per-channel debounce and edge-event stage for three inputs. It sits directly downstream of the two-flop input synchronizer and consumes its already-synchronized `output_1..3` signals. For each input it produces:
- a debounced level;
- single-cycle rise and fall pulses;
- a saturating count of debounced rising edges.

Downstream control logic reads only these outputs, never the raw synchronized signals.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive cycles a new input value must hold before the level changes; legal range ≥ 2.
- `EVT_W`, default 8: width of each rising-edge event counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `in_1`, `in_2`, `in_3`  in  1 each  synchronized inputs; connect to the synchronizer outputs `output_1..3`.
- `clr_counts`  in  1  synchronous clear of all three event counters.
- `level_1`, `level_2`, `level_3`  out  1 each  debounced level.
- `rise_1`, `rise_2`, `rise_3`  out  1 each  one-cycle pulse when the debounced level goes 0→1.
- `fall_1`, `fall_2`, `fall_3`  out  1 each  one-cycle pulse when the debounced level goes 1→0.
- `count_1`, `count_2`, `count_3`  out  `EVT_W` each  saturating count of rise pulses.
- `any_event`  out  1  OR of all six rise/fall pulses.

## Operation
The three channels are identical and fully independent. Each channel holds:
- `level` register;
- stability counter `stab`, width `$clog2(DEBOUNCE_CYCLES)`;
- `rise` and `fall` registers;
- `count` register.

Per-channel update rule, applied at every clock edge:
- **`in == level`:** `stab <= 0`; level unchanged.
- **`in != level` and `stab < DEBOUNCE_CYCLES-1`:** `stab <= stab+1`.
- **`in != level` and `stab == DEBOUNCE_CYCLES-1`:**
  - `level <= in` and `stab <= 0`;
  - `rise <= in`, `fall <= ~in`.
- **Pulse clearing:** `rise` and `fall` are 0 on every edge where the toggle condition is false, so each pulse is exactly one cycle wide.
- **Glitch rejection:** any sample equal to the current level restarts qualification from zero. Bursts shorter than `DEBOUNCE_CYCLES` are ignored.

Event counter rules:
- **Increment:** on any edge where `rise` is being set to 1, `count <= count+1`, unless `count == 2^EVT_W-1`. In that case the counter saturates and holds.
- **Clear:** `clr_counts=1` sets `count <= 0` on all channels.
- **Priority:** clear takes priority over a coincident increment; that event is not counted.
- **Scope:** `clr_counts` does not affect `level`, `stab` or the pulses.

`any_event` is the combinational OR of the registered `rise_*` and `fall_*` signals, so it introduces no extra latency.

## Timing
- **Reset values (async assert, all outputs):**
  - `level_*`, `rise_*`, `fall_*`, `any_event` = 0;
  - `count_*` = 0;
  - internal `stab` = 0.
- **Reset deassertion:** the first update occurs at the first rising `clk` edge after `rst_n` goes high.
- **Latency:** when `in_x` takes a new value and holds it, `level_x` changes on the `DEBOUNCE_CYCLES`-th consecutive rising edge that samples the new value. The matching pulse is high for the following cycle only, coincident with the new level.
- **Counter timing:** `count_x` updates on the same edge as `rise_x`.
- **End-to-end:** including the 2-cycle synchronizer, total pad-to-level latency is `DEBOUNCE_CYCLES+2` cycles.
- **Reset mid-qualification:** `stab` is lost; qualification restarts after release.
- **Input high at reset release:** produces a rise pulse and a count of 1 after `DEBOUNCE_CYCLES` edges.
- **Multi-channel:** simultaneous toggles on several channels are handled independently in the same cycle. `any_event` is high for that single cycle.
- **Back-to-back events:** consecutive events on one channel are at least `DEBOUNCE_CYCLES` cycles apart by construction.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `EVT_W=4` in the bench.

1. Reset with `in_1=1`, then release:
   - `level_1` rises on the 4th edge;
   - `rise_1=1` for exactly 1 cycle and `count_1=1`;
   - `fall_1` stays 0 throughout.
2. `in_2` pattern 1,1,1,0,1,1,1,1 from `level_2=0`:
   - no change on the first burst of three 1s;
   - `level_2=1` on the 4th edge of the second burst;
   - `rise_2` pulses once and `count_2=1`.
3. Toggle `in_3` 0→1→0, each phase held 6 cycles:
   - `rise_3` then `fall_3`, each exactly 1 cycle wide;
   - `count_3=1`;
   - `any_event` high in exactly 2 cycles.
4. Counter saturation: 20 qualified presses on `in_1`:
   - `count_1` reaches 15 and holds;
   - `rise_1` still pulses on every press.
5. Assert `clr_counts` on the same edge as a `rise_1` with `count_1=5`:
   - `count_1=0` next cycle and `rise_1` still observed;
   - `level_1` unaffected.
6. Assert `rst_n=0` asynchronously mid-clock while `stab_2=2`:
   - all outputs drop to 0 immediately, without waiting for a clock edge;
   - after release, with `in_2=1` held, `level_2` rises only after 4 full edges.
